imem_loader: RTL and testbench
==============================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter MAX_WORDS, default 256: maximum program length in 32-bit words.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  one-cycle pulse requesting a program load.
REQ-005 SHALL have port byte_valid  input  1  byte_data holds a valid stream byte.
REQ-006 SHALL have port byte_data  input  8  stream byte.
REQ-007 SHALL have port byte_ready  output  1  loader accepts a byte this cycle.
REQ-008 SHALL have port imem_we  output  1  instruction-memory write strobe.
REQ-009 SHALL have port imem_addr  output  64  byte address of the word being written.
REQ-010 SHALL have port imem_wdata  output  32  instruction word being written.
REQ-011 SHALL have port core_hold  output  1  1 holds the processor core in reset.
REQ-012 SHALL have port done  output  1  load completed successfully.
REQ-013 SHALL have port error  output  1  load aborted.

Function
REQ-014 A byte SHALL transfer only in a cycle where byte_valid=1 and byte_ready=1.
REQ-015 Stream format SHALL be: count low byte, count high byte (16-bit word count N), then N words of 4 bytes each, least-significant byte first.
REQ-016 FSM states SHALL be IDLE, LEN_LO, LEN_HI, DATA, WRITE, CHK, DONE, ERR.
REQ-017 byte_ready SHALL be 1 in LEN_LO, LEN_HI, DATA and CHK, and 0 in all other states.
REQ-018 IDLE, DONE or ERR with start=1 SHALL go to LEN_LO and clear done, error and the word index; start SHALL be ignored in all other states.
REQ-019 LEN_LO -> LEN_HI on transfer; LEN_HI -> DATA on transfer.
REQ-020 If N=0, LEN_HI SHALL go to CHK when the checksum feature is enabled, otherwise to DONE.
REQ-021 If N>MAX_WORDS, LEN_HI SHALL go to ERR.
REQ-022 DATA SHALL assemble bytes into a 32-bit word; the 4th transfer SHALL go to WRITE.
REQ-023 WRITE SHALL last exactly one cycle with imem_we=1, imem_addr=4*index and imem_wdata=the assembled word.
REQ-024 Leaving WRITE, index SHALL increment, then go to DATA if index<N, else to CHK (feature enabled) or DONE.
REQ-025 imem_we SHALL be 0 in every state except WRITE.
REQ-026 In DONE: done=1 and core_hold=0. In ERR: error=1 and core_hold=1.
REQ-027 core_hold SHALL be 1 in all states except DONE.

Reset
REQ-028 Asserting reset SHALL immediately force: state IDLE, byte_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, done=0, error=0, core_hold=1.
REQ-029 Reset mid-load SHALL discard any partial word and the word index; no imem write SHALL occur after reset assertion.

Configuration
REQ-030 Macro IMEM_LOADER_CHECKSUM_EN defined: a trailing byte SHALL be accepted in CHK; if it equals the XOR of all payload bytes -> DONE, else -> ERR.
REQ-031 Macro IMEM_LOADER_CHECKSUM_EN undefined: CHK and the XOR accumulator SHALL not exist; the last WRITE SHALL go directly to DONE.

Structure
REQ-032 Package imem_loader_pkg SHALL hold the state encoding, header length (2 bytes) and word size (4 bytes).
REQ-033 Sub-module byte_packer SHALL perform the 8-to-32-bit little-endian assembly and keep the byte counter (0..3).

Verification
REQ-034 N=2, bytes 02 00 13 00 00 00 93 00 10 00 -> writes 0x00000013 @0 and 0x00100093 @4, then done=1, core_hold=0.
REQ-035 Same stream with byte_valid toggled every other cycle -> identical writes and result; no byte lost or duplicated.
REQ-036 N=0x0101 with MAX_WORDS=256 -> ERR, error=1, zero imem writes.
REQ-037 reset asserted after 2 payload bytes, then a fresh load with N=1, word 0xDEADBEEF -> single write 0xDEADBEEF @0.
REQ-038 CHECKSUM_EN, N=1, word 0x00000013, checksum 0x13 -> done=1; checksum 0x12 -> error=1, core_hold=1.
REQ-039 start pulsed during DATA -> ignored; the load completes normally.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared encodings and sizes for the instruction-memory loader.
// Macro IMEM_LOADER_CHECKSUM_EN adds the CHK state used by the trailing-checksum feature.
package imem_loader_pkg;

  localparam int HDR_BYTES  = 2;
  localparam int WORD_BYTES = 4;
  localparam int BYTE_CNT_W = $clog2(WORD_BYTES);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEN_LO = 3'd1,
    LEN_HI = 3'd2,
    DATA   = 3'd3,
    WRITE  = 3'd4,
`ifdef IMEM_LOADER_CHECKSUM_EN
    CHK    = 3'd5,
`endif
    DONE   = 3'd6,
    ERR    = 3'd7
  } state_t;

  function automatic logic [63:0] word_addr(input logic [HDR_BYTES*8-1:0] idx);
    return {{(64-HDR_BYTES*8-BYTE_CNT_W){1'b0}}, idx, {BYTE_CNT_W{1'b0}}};
  endfunction

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Little-endian 8-to-32-bit word assembly with a 0..3 byte counter.
// last_byte flags the transfer that completes the current word.
import imem_loader_pkg::*;

module byte_packer (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clear,
  input  logic                    take,
  input  logic [7:0]              byte_data,
  output logic [WORD_BYTES*8-1:0] word,
  output logic                    last_byte
);

  logic [BYTE_CNT_W-1:0] cnt;

  assign last_byte = take && (cnt == BYTE_CNT_W'(WORD_BYTES - 1));

  // Shift in from the top so the first byte ends up in the least-significant lane.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt  <= '0;
      word <= '0;
    end else if (clear) begin
      cnt  <= '0;
      word <= '0;
    end else if (take) begin
      word <= {byte_data, word[WORD_BYTES*8-1:8]};
      cnt  <= last_byte ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Streams a length-prefixed program into instruction memory while holding the core in reset.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
import imem_loader_pkg::*;

// state  | meaning
// IDLE   | waiting for start, core held
// LEN_LO | receiving word-count low byte
// LEN_HI | receiving word-count high byte, range check
// DATA   | receiving payload bytes of the current word
// WRITE  | one-cycle instruction-memory write
// CHK    | receiving checksum byte (checksum build only)
// DONE   | load complete, core released
// ERR    | load aborted, core held
module imem_loader #(
  parameter int MAX_WORDS = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        imem_we,
  output logic [63:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        core_hold,
  output logic        done,
  output logic        error
);

  localparam int CNT_W = HDR_BYTES * 8;
  localparam logic [CNT_W:0] MAX_N = (CNT_W + 1)'(MAX_WORDS);

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_t AFTER_PAYLOAD = CHK;
`else
  localparam state_t AFTER_PAYLOAD = DONE;
`endif

  state_t            state, state_nxt;
  logic [7:0]        len_lo_q;
  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  index_q;
  logic [CNT_W-1:0]  index_inc;
  logic [CNT_W-1:0]  len_full;
  logic              start_accept;
  logic              take;
  logic              last_byte;
  logic [31:0]       word;

  assign start_accept = start && (state == IDLE || state == DONE || state == ERR);
  assign len_full     = {byte_data, len_lo_q};
  assign index_inc    = index_q + 1'b1;
  assign take         = byte_valid && byte_ready && (state == DATA);

  byte_packer u_packer (
    .clk       (clk),
    .reset     (reset),
    .clear     (start_accept),
    .take      (take),
    .byte_data (byte_data),
    .word      (word),
    .last_byte (last_byte)
  );

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] xor_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)            xor_q <= '0;
    else if (start_accept) xor_q <= '0;
    else if (take)         xor_q <= xor_q ^ byte_data;
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    byte_ready = 1'b0;
    case (state)
      IDLE, DONE, ERR: begin
        if (start) state_nxt = LEN_LO;
      end
      LEN_LO: begin
        byte_ready = 1'b1;
        if (byte_valid) state_nxt = LEN_HI;
      end
      LEN_HI: begin
        byte_ready = 1'b1;
        if (byte_valid) begin
          if ({1'b0, len_full} > MAX_N) state_nxt = ERR;
          else if (len_full == '0)      state_nxt = AFTER_PAYLOAD;
          else                          state_nxt = DATA;
        end
      end
      DATA: begin
        byte_ready = 1'b1;
        if (last_byte) state_nxt = WRITE;
      end
      WRITE: begin
        state_nxt = (index_inc < count_q) ? DATA : AFTER_PAYLOAD;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHK: begin
        byte_ready = 1'b1;
        if (byte_valid) state_nxt = (byte_data == xor_q) ? DONE : ERR;
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      len_lo_q <= '0;
      count_q  <= '0;
      index_q  <= '0;
    end else begin
      if (state == LEN_LO && byte_valid) len_lo_q <= byte_data;
      if (state == LEN_HI && byte_valid) count_q <= len_full;
      if (start_accept)          index_q <= '0;
      else if (state == WRITE)   index_q <= index_inc;
    end
  end

  // Address and data are gated to zero outside WRITE so reset forces them low immediately.
  assign imem_we    = (state == WRITE);
  assign imem_addr  = imem_we ? word_addr(index_q) : 64'd0;
  assign imem_wdata = imem_we ? word : 32'd0;
  assign done       = (state == DONE);
  assign error      = (state == ERR);
  assign core_hold  = (state != DONE);

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader (default MAX_WORDS = 256).
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'h00;
  logic        byte_ready;
  logic        imem_we;
  logic [63:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        core_hold;
  logic        done;
  logic        error;

  int checks = 0;
  int errors = 0;

  logic [63:0] wr_addr[$];
  logic [31:0] wr_data[$];
  logic [7:0]  stim[$];

  imem_loader #(.MAX_WORDS(256)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .core_hold  (core_hold),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (imem_we) begin
      wr_addr.push_back(imem_addr);
      wr_data.push_back(imem_wdata);
      checks++;
      if (byte_ready !== 1'b0) begin
        errors++;
        $display("FAIL ready_during_write got %b want 0", byte_ready);
      end
    end
  end

  task automatic clear_writes();
    wr_addr.delete();
    wr_data.delete();
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    for (int i = 0; i < gap; i++) begin
      @(negedge clk);
      byte_valid = 1'b0;
    end
    @(negedge clk);
    byte_valid = 1'b1;
    byte_data  = b;
    t = 0;
    while (!byte_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) begin
      checks++;
      errors++;
      $display("FAIL byte_accept_timeout got ready=0 want ready=1 for byte %h", b);
    end
    @(posedge clk);
    #1 byte_valid = 1'b0;
  endtask

  task automatic send_stim(input int gap);
    foreach (stim[i]) send_byte(stim[i], gap);
  endtask

  task automatic add_checksum();
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] cs;
    cs = 8'h00;
    for (int i = 2; i < stim.size(); i++) cs ^= stim[i];
    stim.push_back(cs);
`endif
  endtask

  task automatic wait_end();
    int t;
    t = 0;
    while (!(done || error) && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (t >= 40) begin
      checks++;
      errors++;
      $display("FAIL completion_timeout got done=%b error=%b want one of them set", done, error);
    end
  endtask

  task automatic load_program_stim();
    stim = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    add_checksum();
  endtask

  task automatic test_reset();
    #2;
    checks += 7;
    if (byte_ready !== 1'b0)    begin errors++; $display("FAIL rst_ready got %b want 0", byte_ready); end
    if (imem_we !== 1'b0)       begin errors++; $display("FAIL rst_we got %b want 0", imem_we); end
    if (imem_addr !== 64'd0)    begin errors++; $display("FAIL rst_addr got %h want 0", imem_addr); end
    if (imem_wdata !== 32'd0)   begin errors++; $display("FAIL rst_wdata got %h want 0", imem_wdata); end
    if (done !== 1'b0)          begin errors++; $display("FAIL rst_done got %b want 0", done); end
    if (error !== 1'b0)         begin errors++; $display("FAIL rst_error got %b want 0", error); end
    if (core_hold !== 1'b1)     begin errors++; $display("FAIL rst_hold got %b want 1", core_hold); end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks += 2;
    if (byte_ready !== 1'b0) begin errors++; $display("FAIL idle_ready got %b want 0", byte_ready); end
    if (core_hold !== 1'b1)  begin errors++; $display("FAIL idle_hold got %b want 1", core_hold); end
  endtask

  task automatic test_basic(input int gap, input string tag);
    load_program_stim();
    clear_writes();
    pulse_start();
    send_stim(gap);
    wait_end();
    checks += 8;
    if (wr_addr.size() !== 2) begin
      errors++;
      $display("FAIL %s_nwrites got %0d want 2", tag, wr_addr.size());
    end else begin
      if (wr_addr[0] !== 64'd0)        begin errors++; $display("FAIL %s_addr0 got %h want 0", tag, wr_addr[0]); end
      if (wr_data[0] !== 32'h00000013) begin errors++; $display("FAIL %s_data0 got %h want 00000013", tag, wr_data[0]); end
      if (wr_addr[1] !== 64'd4)        begin errors++; $display("FAIL %s_addr1 got %h want 4", tag, wr_addr[1]); end
      if (wr_data[1] !== 32'h00100093) begin errors++; $display("FAIL %s_data1 got %h want 00100093", tag, wr_data[1]); end
    end
    if (done !== 1'b1)      begin errors++; $display("FAIL %s_done got %b want 1", tag, done); end
    if (error !== 1'b0)     begin errors++; $display("FAIL %s_error got %b want 0", tag, error); end
    if (core_hold !== 1'b0) begin errors++; $display("FAIL %s_hold got %b want 0", tag, core_hold); end
  endtask

  task automatic test_start_in_data();
    load_program_stim();
    clear_writes();
    pulse_start();
    for (int i = 0; i < 3; i++) send_byte(stim[i], 0);
    pulse_start();
    for (int i = 3; i < stim.size(); i++) send_byte(stim[i], 0);
    wait_end();
    checks += 4;
    if (wr_addr.size() !== 2) begin
      errors++;
      $display("FAIL startdata_nwrites got %0d want 2", wr_addr.size());
    end else begin
      if (wr_data[0] !== 32'h00000013) begin errors++; $display("FAIL startdata_data0 got %h want 00000013", wr_data[0]); end
      if (wr_data[1] !== 32'h00100093) begin errors++; $display("FAIL startdata_data1 got %h want 00100093", wr_data[1]); end
    end
    if (done !== 1'b1) begin errors++; $display("FAIL startdata_done got %b want 1", done); end
  endtask

  task automatic test_zero_len();
    stim = '{8'h00, 8'h00};
    add_checksum();
    clear_writes();
    pulse_start();
    send_stim(0);
    wait_end();
    checks += 3;
    if (wr_addr.size() !== 0) begin errors++; $display("FAIL zero_nwrites got %0d want 0", wr_addr.size()); end
    if (done !== 1'b1)        begin errors++; $display("FAIL zero_done got %b want 1", done); end
    if (core_hold !== 1'b0)   begin errors++; $display("FAIL zero_hold got %b want 0", core_hold); end
  endtask

  task automatic test_oversize();
    stim = '{8'h01, 8'h01};
    clear_writes();
    pulse_start();
    send_stim(0);
    wait_end();
    repeat (3) @(negedge clk);
    checks += 5;
    if (wr_addr.size() !== 0) begin errors++; $display("FAIL over_nwrites got %0d want 0", wr_addr.size()); end
    if (error !== 1'b1)       begin errors++; $display("FAIL over_error got %b want 1", error); end
    if (done !== 1'b0)        begin errors++; $display("FAIL over_done got %b want 0", done); end
    if (core_hold !== 1'b1)   begin errors++; $display("FAIL over_hold got %b want 1", core_hold); end
    if (byte_ready !== 1'b0)  begin errors++; $display("FAIL over_ready got %b want 0", byte_ready); end
    // N = 256 is exactly the limit and must be accepted.
    stim = '{8'h00, 8'h01};
    pulse_start();
    send_stim(0);
    repeat (3) @(negedge clk);
    checks += 2;
    if (error !== 1'b0)      begin errors++; $display("FAIL max_error got %b want 0", error); end
    if (byte_ready !== 1'b1) begin errors++; $display("FAIL max_ready got %b want 1", byte_ready); end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset_mid_load();
    stim = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    add_checksum();
    clear_writes();
    pulse_start();
    for (int i = 0; i < 4; i++) send_byte(stim[i], 0);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    checks += 3;
    if (byte_ready !== 1'b0) begin errors++; $display("FAIL midrst_ready got %b want 0", byte_ready); end
    if (core_hold !== 1'b1)  begin errors++; $display("FAIL midrst_hold got %b want 1", core_hold); end
    if (imem_we !== 1'b0)    begin errors++; $display("FAIL midrst_we got %b want 0", imem_we); end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (wr_addr.size() !== 0) begin errors++; $display("FAIL midrst_nwrites got %0d want 0", wr_addr.size()); end
    clear_writes();
    pulse_start();
    send_stim(0);
    wait_end();
    checks += 2;
    if (wr_addr.size() !== 1) begin
      errors++;
      $display("FAIL reload_nwrites got %0d want 1", wr_addr.size());
    end else if (wr_addr[0] !== 64'd0 || wr_data[0] !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL reload_write got %h@%h want deadbeef@0", wr_data[0], wr_addr[0]);
    end
    if (done !== 1'b1) begin errors++; $display("FAIL reload_done got %b want 1", done); end
  endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    stim = '{8'h01, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h13};
    pulse_start();
    send_stim(0);
    wait_end();
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL cs_good_done got %b want 1", done); end
    stim = '{8'h01, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h12};
    pulse_start();
    send_stim(0);
    wait_end();
    checks += 2;
    if (error !== 1'b1)     begin errors++; $display("FAIL cs_bad_error got %b want 1", error); end
    if (core_hold !== 1'b1) begin errors++; $display("FAIL cs_bad_hold got %b want 1", core_hold); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic(0, "basic");
    test_basic(1, "toggle");
    test_start_in_data();
    test_zero_len();
    test_oversize();
    test_reset_mid_load();
`ifdef IMEM_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
